mult_add: RTL

MULT_ADD -- requirements
Module: mult_add

---
 rtl/mult_pkg.sv | 16 +
 rtl/abs_neg.sv | 18 +
 rtl/mult_add.sv | 105 ++++++++++
 3 files changed

// File: rtl/mult_pkg.sv
// mult_pkg: shared definitions for the mult_add shift-add multiplier.
//   state_t   controller state encoding (ST_IDLE / ST_RUN / ST_FINISH)
//   cnt_w()   width of an iteration counter able to hold the value w
package mult_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_FINISH = 2'd2
  } state_t;

  function automatic int cnt_w(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/abs_neg.sv
// abs_neg: conditional two's-complement.
//   val  in   W-bit operand
//   neg  in   1 = output -val (mod 2^W), 0 = pass val through
//   res  out  W-bit result
// Used as magnitude extractor for operands (neg = sign & MSB) and as the
// final result negator. The most negative value maps onto itself, which
// read as unsigned is exactly its magnitude.
module abs_neg #(
  parameter int W = 8
) (
  input  logic [W-1:0] val,
  input  logic         neg,
  output logic [W-1:0] res
);

  assign res = neg ? (~val + W'(1)) : val;

endmodule

// File: rtl/mult_add.sv
// mult_add: sequential shift-add multiply-accumulate,
//   product = multiplicand * multiplier + addend  (mod 2^(2*WIDTH))
// Ports:
//   clk          in   clock, rising edge
//   reset_n      in   async active-low reset
//   start        in   sample operands + sign, (re)start an operation
//   sign         in   0 = unsigned, 1 = two's complement
//   multiplicand in   WIDTH
//   multiplier   in   WIDTH
//   addend       in   WIDTH, zero/sign extended per sign
//   product      out  2*WIDTH, held until the next result write
//   ready        out  one-cycle pulse with a new product
//   busy         out  high in RUN and FINISH
// Build option: define MULT_EARLY_EXIT_EN to leave RUN as soon as the
// remaining multiplier bits are all zero (latency 2..WIDTH+1 edges);
// otherwise latency is a fixed WIDTH+1 edges.
module mult_add
  import mult_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic               sign,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  input  logic [WIDTH-1:0]   addend,
  output logic [2*WIDTH-1:0] product,
  output logic               ready,
  output logic               busy
);

  localparam int CW = cnt_w(WIDTH);

  state_t             state, state_nxt;
  logic [2*WIDTH-1:0] mcand_q, acc_q, addend_q, acc_res;
  logic [WIDTH-1:0]   mplier_q, mcand_mag, mplier_mag;
  logic [CW-1:0]      cnt_q;
  logic               negate_q, last_iter;

  abs_neg #(.W(WIDTH)) u_abs_mcand (
    .val(multiplicand), .neg(sign & multiplicand[WIDTH-1]), .res(mcand_mag));
  abs_neg #(.W(WIDTH)) u_abs_mplier (
    .val(multiplier),   .neg(sign & multiplier[WIDTH-1]),   .res(mplier_mag));
  abs_neg #(.W(2*WIDTH)) u_neg_res (
    .val(acc_q),        .neg(negate_q),                     .res(acc_res));

  // Last iteration: counter about to expire, or (early exit) the
  // multiplier after this cycle's shift has no set bits left.
`ifdef MULT_EARLY_EXIT_EN
  assign last_iter = (cnt_q == CW'(1)) || (mplier_q[WIDTH-1:1] == '0);
`else
  assign last_iter = (cnt_q == CW'(1));
`endif

  assign busy = (state != ST_IDLE);

  always_comb begin
    state_nxt = state;
    if (start) begin
      state_nxt = ST_RUN;          // start always (re)launches, aborting any op
    end else begin
      case (state)
        ST_RUN:    if (last_iter) state_nxt = ST_FINISH;
        ST_FINISH: state_nxt = ST_IDLE;
        default:   state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      addend_q <= '0;
      cnt_q    <= '0;
      negate_q <= 1'b0;
      product  <= '0;
      ready    <= 1'b0;
    end else begin
      state <= state_nxt;
      ready <= 1'b0;
      if (start) begin
        mcand_q  <= {{WIDTH{1'b0}}, mcand_mag};
        mplier_q <= mplier_mag;
        acc_q    <= '0;
        cnt_q    <= CW'(WIDTH);
        negate_q <= sign & (multiplicand[WIDTH-1] ^ multiplier[WIDTH-1]);
        addend_q <= {{WIDTH{sign & addend[WIDTH-1]}}, addend};
      end else if (state == ST_RUN) begin
        if (mplier_q[0]) acc_q <= acc_q + mcand_q;
        mcand_q  <= mcand_q << 1;
        mplier_q <= mplier_q >> 1;
        cnt_q    <= cnt_q - CW'(1);
      end else if (state == ST_FINISH) begin
        product <= acc_res + addend_q;
        ready   <= 1'b1;
      end
    end
  end

endmodule
